axi_line_master: RTL and testbench
==================================

# axi_line_master

AXI4 burst master that turns single cache-line read/write requests from the core-side memory arbiter into fixed-length INCR bursts on an `axi_interface.master` port. It sits directly upstream of the simulation DDR slave and of the FPGA memory controller in synthesis. It runs one transaction at a time: a full line read, or a full line write with streamed write data. Responses are returned to the requester beat by beat.

## Interface
Parameters:
- LINE_WORDS, 8, burst length in 32-bit words; power of two, 1..16
- ID_WIDTH, 6, width of request/AXI id

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  line request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_rnw  in  1  1 = read line, 0 = write line
- req_addr  in  32  byte address; low log2(LINE_WORDS*4) bits ignored
- req_id  in  ID_WIDTH  id placed on arid/awid
- wr_data  in  32  write beat data
- wr_be  in  4  write beat byte enables
- wr_data_valid  in  1  write beat valid
- wr_data_ready  out  1  write beat consumed when valid & ready
- rd_data  out  32  read beat data
- rd_data_valid  out  1  read beat valid (no backpressure)
- rd_last  out  1  final beat of line
- rd_id  out  ID_WIDTH  rid of current beat
- wr_done  out  1  one-cycle pulse, write response received
- err  out  1  sticky: any rresp/bresp != 0
- rd_line_count  out  32  completed line reads (see Configuration)
- wr_line_count  out  32  completed line writes (see Configuration)
- axi  axi_interface.master  AXI4 master port

## Operation
- FSM states: IDLE, AR, R, AW, W, B. Reset → IDLE.
- IDLE: req_ready=1. On accept, latch aligned address ({req_addr[31:L], L'b0}, L=log2(LINE_WORDS*4)) and id; go to AR if req_rnw, else AW.
- AR: arvalid=1, araddr=latched, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01, arcache=4'b0011, arid=latched id. On arready → R.
- R: rready=1. rd_data/rd_data_valid/rd_last/rd_id are pass-through of rdata/rvalid/rlast/rid. rresp!=0 on any beat sets err. On rvalid & rlast → IDLE.
- AW: awvalid=1, AW fields as for AR. On awready → W. Beat counter cleared.
- W: wvalid = wr_data_valid; wdata = wr_data; wstrb = wr_be; wr_data_ready = wready. wlast=1 when beat counter == LINE_WORDS-1. Each wvalid & wready increments the counter; the last beat → B.
- B: bready=1. On bvalid: wr_done=1 that cycle, bresp!=0 sets err → IDLE.
- No W beats before AW handshake completes. Exactly LINE_WORDS W beats per write.
- Outside R, rd_data_valid=0. Outside W, wvalid=0 and wr_data_ready=0.

## Timing
- Reset values: state IDLE; arvalid, awvalid, wvalid, rready, bready, rd_data_valid, wr_done, err = 0. req_ready=0 while rst is high.
- Request accepted at edge T → arvalid/awvalid high from T+1. Held stable until handshake.
- Read completes: IDLE (req_ready=1) in the cycle after the rlast handshake.
- Write completes: IDLE in the cycle after the bvalid handshake.
- Minimum read latency from accept to first beat: 2 cycles plus slave latency.
- rvalid without rlast while in R is consumed normally. Extra beats outside R are ignored (rready=0).
- err is cleared only by rst.
- rst mid-transaction abandons it. All valid/ready outputs are 0 from the next edge. The slave must be reset together.

## Configuration
- AXI_LINE_MASTER_STATS_EN defined: rd_line_count increments on each rlast handshake. wr_line_count increments on each bvalid handshake. Both are 32-bit, reset to 0, and wrap 0xFFFFFFFF→0.
- Not defined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Read req_addr=0x8000_0014, LINE_WORDS=8 → araddr=0x8000_0000, arlen=7. 8 rd_data_valid beats with memory words 0..7. rd_last on the 8th beat only. req_ready back in the cycle after.
- Write req_addr=0x8000_0040, 8 beats 0xA0..0xA7 with wr_be=4'hF, wr_data_valid toggled every other cycle → wlast only on beat 8, no W before AW handshake. Single wr_done pulse. Readback of the same line matches.
- Slave holds arready/awready/wready low for 5 cycles → arvalid, awvalid and AW fields stay stable, no beats lost.
- Slave returns bresp=2'b10 → err=1 and stays 1 through subsequent good reads until rst.
- rst asserted during the W state after beat 3 → all AXI valids 0 next cycle. After release, a new read completes correctly.
- With AXI_LINE_MASTER_STATS_EN: 3 reads and 2 writes → rd_line_count=3, wr_line_count=2. Without the macro, both read 0.

Source files
------------

// File: rtl/axi_line_master_if.sv
// axi_interface: AXI4 read/write channel bundle used between line masters
// and memory slaves. 32-bit address and data, ID_WIDTH-bit ids.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised it stays high,
// with its payload unchanged, until that edge. Ready may rise or fall freely.
//
// Modports:
//   master - drives AW/W/AR payloads + valids, bready/rready
//   slave  - drives awready/wready/arready, B and R payloads + valids
interface axi_interface #(
  parameter int ID_WIDTH = 6
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [3:0]          arcache;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_line_master.sv
// axi_line_master: turns single cache-line read/write requests into one
// fixed-length INCR burst on an AXI4 master port, one transaction at a time.
//
// Handshakes: every valid/ready pair (req_*, wr_data_*, AXI channels)
// transfers on a rising clk edge where both are high; a raised valid holds
// its payload until that edge. rd_data_valid and wr_done have no ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   line request handshake (req_rnw, req_addr, req_id)
//   wr_data/wr_be         write beat stream, wr_data_valid/wr_data_ready
//   rd_data/rd_last/rd_id read beat stream qualified by rd_data_valid
//   wr_done               one-cycle pulse on write response
//   err                   sticky error flag, any non-OKAY rresp/bresp
//   rd_line_count         completed line reads
//   wr_line_count         completed line writes
//   state_dbg             current FSM state encoding
//   axi                   AXI4 master port
//
// Build option: define AXI_LINE_MASTER_STATS_EN to get the two 32-bit line
// counters; without it both counters read 0 and no counter flops exist.
module axi_line_master #(
  parameter int LINE_WORDS = 8,
  parameter int ID_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rnw,
  input  logic [31:0]         req_addr,
  input  logic [ID_WIDTH-1:0] req_id,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_be,
  input  logic                wr_data_valid,
  output logic                wr_data_ready,
  output logic [31:0]         rd_data,
  output logic                rd_data_valid,
  output logic                rd_last,
  output logic [ID_WIDTH-1:0] rd_id,
  output logic                wr_done,
  output logic                err,
  output logic [31:0]         rd_line_count,
  output logic [31:0]         wr_line_count,
  output logic [2:0]          state_dbg,
  axi_interface.master        axi
);

  localparam logic [31:0] OFS_MASK = 32'((LINE_WORDS * 4) - 1);
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t              state, state_next;
  logic [31:0]         line_addr;
  logic [ID_WIDTH-1:0] line_id;
  logic [CW-1:0]       beat;
  logic                err_q;
  logic                ar_v, aw_v, w_v, w_last, r_rdy, b_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    ar_v          = 1'b0;
    aw_v          = 1'b0;
    w_v           = 1'b0;
    w_last        = 1'b0;
    wr_data_ready = 1'b0;
    r_rdy         = 1'b0;
    b_rdy         = 1'b0;
    rd_data_valid = 1'b0;
    rd_last       = 1'b0;
    wr_done       = 1'b0;
    case (state)
      IDLE: begin
        // Reset is synchronous, so gate ready directly to refuse requests
        // in cycles where rst is held.
        req_ready = ~rst;
        if (req_valid) state_next = req_rnw ? AR : AW;
      end
      AR: begin
        ar_v = 1'b1;
        if (axi.arready) state_next = R;
      end
      R: begin
        r_rdy         = 1'b1;
        rd_data_valid = axi.rvalid;
        rd_last       = axi.rlast;
        if (axi.rvalid && axi.rlast) state_next = IDLE;
      end
      AW: begin
        aw_v = 1'b1;
        if (axi.awready) state_next = W;
      end
      W: begin
        w_v           = wr_data_valid;
        wr_data_ready = axi.wready;
        w_last        = (beat == LAST_BEAT);
        if (wr_data_valid && axi.wready && w_last) state_next = B;
      end
      B: begin
        b_rdy = 1'b1;
        if (axi.bvalid) begin
          wr_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= '0;
      line_id   <= '0;
      beat      <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        line_addr <= req_addr & ~OFS_MASK;
        line_id   <= req_id;
      end
      if (state == AW)               beat <= '0;
      else if (w_v && axi.wready)    beat <= beat + 1'b1;
      if ((r_rdy && axi.rvalid && axi.rresp != 2'b00) ||
          (b_rdy && axi.bvalid && axi.bresp != 2'b00))
        err_q <= 1'b1;
    end
  end

`ifdef AXI_LINE_MASTER_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (r_rdy && axi.rvalid && axi.rlast) rd_cnt <= rd_cnt + 32'd1;
      if (b_rdy && axi.bvalid)              wr_cnt <= wr_cnt + 32'd1;
    end
  end

  assign rd_line_count = rd_cnt;
  assign wr_line_count = wr_cnt;
`else
  assign rd_line_count = '0;
  assign wr_line_count = '0;
`endif

  assign err       = err_q;
  assign state_dbg = state;
  assign rd_data   = axi.rdata;
  assign rd_id     = axi.rid;

  // AR and AW share one latched line address/id; only the valids differ.
  assign axi.arvalid = ar_v;
  assign axi.araddr  = line_addr;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arcache = 4'b0011;
  assign axi.arid    = line_id;

  assign axi.awvalid = aw_v;
  assign axi.awaddr  = line_addr;
  assign axi.awlen   = 8'(LINE_WORDS - 1);
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awcache = 4'b0011;
  assign axi.awid    = line_id;

  assign axi.wvalid = w_v;
  assign axi.wdata  = wr_data;
  assign axi.wstrb  = wr_be;
  assign axi.wlast  = w_last;

  assign axi.rready = r_rdy;
  assign axi.bready = b_rdy;

endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: randomized/directed bench for axi_line_master with a
// behavioural AXI memory slave, a line-level reference memory and
// scoreboard queues checked by independent monitor processes.
module tb_axi_line_master;

  localparam int LW  = 8;
  localparam int IDW = 6;
  localparam int MW  = 1024;
  localparam int RW  = 33 + IDW;
  localparam logic [31:0] LMASK = 32'(LW * 4 - 1);
`ifdef AXI_LINE_MASTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_rnw;
  logic [31:0]     req_addr;
  logic [IDW-1:0]  req_id;
  logic [31:0]     wr_data;
  logic [3:0]      wr_be;
  logic            wr_data_valid, wr_data_ready;
  logic [31:0]     rd_data;
  logic            rd_data_valid, rd_last;
  logic [IDW-1:0]  rd_id;
  logic            wr_done, err;
  logic [31:0]     rd_line_count, wr_line_count;
  logic [2:0]      state_dbg;

  axi_interface #(.ID_WIDTH(IDW)) axi ();

  axi_line_master #(.LINE_WORDS(LW), .ID_WIDTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_id(req_id),
    .wr_data(wr_data), .wr_be(wr_be),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last),
    .rd_id(rd_id), .wr_done(wr_done), .err(err),
    .rd_line_count(rd_line_count), .wr_line_count(wr_line_count),
    .state_dbg(state_dbg), .axi(axi)
  );

  // ---------------- bookkeeping ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and slave storage (word index = addr[11:2])
  logic [31:0] ref_mem   [MW];
  logic [31:0] slave_mem [MW];
  logic [31:0] wdat [LW];
  logic [3:0]  wbe  [LW];

  logic [63:0]   ar_exp_q[$];
  logic [63:0]   aw_exp_q[$];
  logic [RW-1:0] rd_exp_q[$];
  logic [0:0]    wr_exp_q[$];

  bit       stall_fixed = 1'b0;
  logic [1:0] bresp_inject = 2'b00;
  logic [1:0] rresp_inject = 2'b00;
  bit       exp_err = 1'b0;
  int       exp_rd_lines = 0;
  int       exp_wr_lines = 0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [63:0] ax_exp(input logic [31:0] a, input logic [IDW-1:0] id);
    logic [31:0] line;
    line = a & ~LMASK;
    return {9'd0, line, 8'(LW - 1), 3'b010, 2'b01, 4'b0011, id};
  endfunction

  // ---------------- AXI memory slave ----------------
  int          ar_cnt, aw_cnt, w_cnt;
  bit          ar_seen, aw_seen, rd_act, wr_act, b_pend, r_hold;
  logic [63:0] ar_hold, aw_hold, cur_ax;
  logic [31:0] rd_base, wr_base;
  int          rd_beat, wr_beat;
  logic [IDW-1:0] rd_idv;

  initial begin : slave
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rdata = 0; axi.rlast = 0; axi.rid = 0; axi.rresp = 0;
    axi.bvalid = 0; axi.bresp = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_seen = 0; aw_seen = 0;
    rd_act = 0; wr_act = 0; b_pend = 0; r_hold = 0; rd_beat = 0; wr_beat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_seen = 0; aw_seen = 0;
        rd_act = 0; wr_act = 0; b_pend = 0; r_hold = 0;
      end else begin
        // AR channel: fields must hold steady while waiting for arready
        if (ar_seen && !axi.arvalid) check("ar_valid_dropped", 0, 1);
        if (axi.arvalid) begin
          cur_ax = {9'd0, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arcache, axi.arid};
          if (ar_seen) check("ar_stable", cur_ax, ar_hold);
          if (axi.arready) begin
            if (ar_exp_q.size() == 0) check("ar_unexpected", 1, 0);
            else check("ar_fields", cur_ax, ar_exp_q.pop_front());
            rd_act = 1; rd_base = axi.araddr; rd_beat = 0; rd_idv = axi.arid;
            ar_seen = 0; ar_cnt = 0;
          end else begin
            ar_seen = 1; ar_hold = cur_ax; ar_cnt++;
          end
        end else ar_seen = 0;
        // R channel
        r_hold = axi.rvalid && !axi.rready;
        if (axi.rvalid && axi.rready) begin
          rd_beat++;
          if (rd_beat == LW) rd_act = 0;
        end
        // AW channel
        if (aw_seen && !axi.awvalid) check("aw_valid_dropped", 0, 1);
        if (axi.awvalid) begin
          cur_ax = {9'd0, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awid};
          if (aw_seen) check("aw_stable", cur_ax, aw_hold);
          if (axi.awready) begin
            if (aw_exp_q.size() == 0) check("aw_unexpected", 1, 0);
            else check("aw_fields", cur_ax, aw_exp_q.pop_front());
            wr_act = 1; wr_base = axi.awaddr; wr_beat = 0;
            aw_seen = 0; aw_cnt = 0;
          end else begin
            aw_seen = 1; aw_hold = cur_ax; aw_cnt++;
          end
        end else aw_seen = 0;
        // W channel: no beat may appear without an accepted AW
        if (axi.wvalid && !wr_act) check("w_without_aw", 1, 0);
        else if (axi.wvalid && axi.wready) begin
          check("wlast", axi.wlast, (wr_beat == LW - 1));
          for (int b = 0; b < 4; b++)
            if (axi.wstrb[b]) slave_mem[widx(wr_base) + wr_beat][b*8 +: 8] = axi.wdata[b*8 +: 8];
          wr_beat++; w_cnt = 0;
          if (wr_beat == LW) begin wr_act = 0; b_pend = 1; end
        end else if (axi.wvalid) w_cnt++;
        // B channel
        if (axi.bvalid && axi.bready) b_pend = 0;
      end
      @(posedge clk);
      #1;
      axi.arready = stall_fixed ? (ar_cnt >= 5) : ($urandom_range(0, 3) != 0);
      axi.awready = stall_fixed ? (aw_cnt >= 5) : ($urandom_range(0, 3) != 0);
      axi.wready  = stall_fixed ? (w_cnt  >= 5) : ($urandom_range(0, 3) != 0);
      if (!r_hold) begin
        if (rd_act) begin
          axi.rvalid = stall_fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
          axi.rdata  = slave_mem[widx(rd_base) + rd_beat];
          axi.rlast  = (rd_beat == LW - 1);
          axi.rid    = rd_idv;
          axi.rresp  = rresp_inject;
        end else begin
          axi.rvalid = 0; axi.rlast = 0;
        end
      end
      axi.bvalid = b_pend;
      axi.bresp  = bresp_inject;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_data_valid) begin
          if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
          else check("rd_beat", {rd_id, rd_last, rd_data}, rd_exp_q.pop_front());
        end
        if (wr_done) begin
          if (wr_exp_q.size() == 0) check("wr_done_unexpected", 1, 0);
          else void'(wr_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_counts(input string tag);
    check({tag, "_rd_line_count"}, rd_line_count, STATS ? 64'(exp_rd_lines) : 64'd0);
    check({tag, "_wr_line_count"}, wr_line_count, STATS ? 64'(exp_wr_lines) : 64'd0);
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk); #1;
    rst = 1; req_valid = 0; wr_data_valid = 0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    check("rst_outputs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                          rd_data_valid, wr_done, wr_data_ready, req_ready, err}, 10'b0);
    ar_exp_q.delete(); aw_exp_q.delete(); rd_exp_q.delete(); wr_exp_q.delete();
    exp_err = 0; exp_rd_lines = 0; exp_wr_lines = 0;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_ready_err", {req_ready, err}, 2'b10);
    check_counts("post_rst");
  endtask

  task automatic send_req(input bit rnw, input logic [31:0] addr, input logic [IDW-1:0] id);
    int n;
    @(posedge clk); #1;
    req_valid = 1; req_rnw = rnw; req_addr = addr; req_id = id;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("req_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [IDW-1:0] id);
    logic [31:0] line;
    int n;
    line = addr & ~LMASK;
    ar_exp_q.push_back(ax_exp(addr, id));
    for (int i = 0; i < LW; i++)
      rd_exp_q.push_back({id, (i == LW - 1), ref_mem[widx(line) + i]});
    send_req(1'b1, addr, id);
    n = 0;
    while (rd_exp_q.size() != 0 && n < 2000) begin @(negedge clk); #1; n++; end
    if (rd_exp_q.size() != 0) begin
      check("rd_timeout_beats_left", rd_exp_q.size(), 0);
      rd_exp_q.delete();
    end else begin
      @(negedge clk);
      check("rd_idle_after_last", req_ready, 1);
      exp_rd_lines++;
      check("rd_err", err, exp_err);
    end
  endtask

  // mode: 0 = valid every cycle, 1 = every other cycle, 2 = random
  // stop_at < LW abandons the write with a reset after that many beats
  task automatic do_write(input logic [31:0] addr, input logic [IDW-1:0] id,
                          input int mode, input int stop_at);
    logic [31:0] line;
    int beat, cyc, n;
    line = addr & ~LMASK;
    aw_exp_q.push_back(ax_exp(addr, id));
    if (stop_at == LW) wr_exp_q.push_back(1'b1);
    send_req(1'b0, addr, id);
    beat = 0; cyc = 0;
    while (beat < stop_at && cyc < 3000) begin
      @(posedge clk); #1;
      wr_data = wdat[beat]; wr_be = wbe[beat];
      case (mode)
        0:       wr_data_valid = 1'b1;
        1:       wr_data_valid = (cyc % 2 == 0);
        default: wr_data_valid = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      @(negedge clk);
      if (wr_data_valid && wr_data_ready) beat++;
    end
    check("w_beats_taken", beat, stop_at);
    // Every accepted beat lands in memory, including those of an abandoned line.
    for (int i = 0; i < beat; i++)
      for (int b = 0; b < 4; b++)
        if (wbe[i][b]) ref_mem[widx(line) + i][b*8 +: 8] = wdat[i][b*8 +: 8];
    if (stop_at < LW) begin
      apply_reset(2);
    end else begin
      @(posedge clk); #1 wr_data_valid = 0;
      n = 0;
      while (wr_exp_q.size() != 0 && n < 2000) begin @(negedge clk); #1; n++; end
      if (wr_exp_q.size() != 0) begin
        check("wr_done_timeout", wr_exp_q.size(), 0);
        wr_exp_q.delete();
      end else begin
        @(negedge clk);
        check("wr_idle_after_b", req_ready, 1);
        exp_wr_lines++;
        check("wr_err", err, exp_err);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < LW; i++) begin
      wdat[i] = $urandom;
      wbe[i]  = 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    req_valid = 0; req_rnw = 0; req_addr = 0; req_id = 0;
    wr_data = 0; wr_be = 0; wr_data_valid = 0;
    for (int i = 0; i < MW; i++) begin
      ref_mem[i]   = 32'(i);
      slave_mem[i] = 32'(i);
    end

    apply_reset(3);

    // unaligned read of line 0: words 0..7
    do_read(32'h8000_0014, 6'd5);

    // directed write with toggling valid, then readback
    for (int i = 0; i < LW; i++) begin
      wdat[i] = 32'hA0 + 32'(i);
      wbe[i]  = 4'hF;
    end
    do_write(32'h8000_0040, 6'd9, 1, LW);
    do_read(32'h8000_0044, 6'd10);

    // slave stalls every ready for 5 cycles
    stall_fixed = 1'b1;
    fill_random();
    do_write(32'h8000_0080, 6'd3, 0, LW);
    do_read(32'h8000_009C, 6'd4);
    stall_fixed = 1'b0;
    check_counts("after_3rd_2wr");

    // error response on B, then sticky through clean reads
    bresp_inject = 2'b10;
    exp_err = 1'b1;
    fill_random();
    do_write(32'h8000_00C0, 6'd7, 2, LW);
    bresp_inject = 2'b00;
    do_read(32'h8000_0000, 6'd1);
    do_read(32'h8000_00C0, 6'd2);

    // reset in the middle of the W phase after 3 beats
    fill_random();
    do_write(32'h8000_0100, 6'd11, 0, 3);
    do_read(32'h8000_0200, 6'd12);
    do_read(32'h8000_0100, 6'd13);

    // randomized traffic
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read(32'h8000_0000 | 32'($urandom_range(0, 4095)), IDW'($urandom));
      end else begin
        fill_random();
        do_write(32'h8000_0000 | 32'($urandom_range(0, 4095)), IDW'($urandom),
                 $urandom_range(0, 2), LW);
      end
    end

    // read error response, then sticky through a clean read
    rresp_inject = 2'b10;
    exp_err = 1'b1;
    do_read(32'h8000_0300, 6'd20);
    rresp_inject = 2'b00;
    do_read(32'h8000_0340, 6'd21);

    check_counts("final");
    check("queues_drained", ar_exp_q.size() + aw_exp_q.size() + rd_exp_q.size() + wr_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #2000000;
    check("watchdog_timeout", 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
